// File: rtl/dual_mac_pkg.sv
// Shared parameters, FSM state type and bus payload types for the dual
// multiplier MAC controller and its multiplier datapath.
package dual_mac_pkg;

    localparam int unsigned DATA_W      = 8;   // operand width (a, b signed; c unsigned)
    localparam int unsigned PROD_W      = 16;  // signed product width
    localparam int unsigned ACC_W       = 32;  // signed accumulator width, wraps
    localparam int unsigned LEN_W       = 9;   // command length width, lengths 0..256
    localparam int unsigned MULT_LAT    = 4;   // multiplier en -> valid_out latency
    localparam int unsigned WDOG_CYCLES = 2 * MULT_LAT;
    localparam int unsigned WDOG_W      = $clog2(WDOG_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // One operand triple as issued to the multiplier.
    typedef struct packed {
        logic signed [DATA_W-1:0] a;
        logic signed [DATA_W-1:0] b;
        logic        [DATA_W-1:0] c;
    } operand_t;

    // One product pair as returned by the multiplier.
    typedef struct packed {
        logic signed [PROD_W-1:0] ac;
        logic signed [PROD_W-1:0] bc;
    } product_t;

    // Sign-extend a product to accumulator width.
    function automatic logic signed [ACC_W-1:0] sext_prod(input logic signed [PROD_W-1:0] p);
        return {{(ACC_W - PROD_W){p[PROD_W-1]}}, p};
    endfunction

endpackage

// File: rtl/dual_mult_mac_ctrl_if.sv
// Controller <-> dsp_dual_mult bus.
//   master (controller): drives m_rst, m_en, m_a, m_b, m_c; receives m_ac, m_bc, m_valid
//   slave  (multiplier): the reverse
interface dual_mult_mac_ctrl_if;
    import dual_mac_pkg::*;

    logic                     m_rst;
    logic                     m_en;
    logic signed [DATA_W-1:0] m_a;
    logic signed [DATA_W-1:0] m_b;
    logic        [DATA_W-1:0] m_c;
    logic signed [PROD_W-1:0] m_ac;
    logic signed [PROD_W-1:0] m_bc;
    logic                     m_valid;

    modport master (
        output m_rst, m_en, m_a, m_b, m_c,
        input  m_ac, m_bc, m_valid
    );

    modport slave (
        input  m_rst, m_en, m_a, m_b, m_c,
        output m_ac, m_bc, m_valid
    );

endinterface

// File: rtl/dsp_dual_mult.sv
// Fully pipelined dual multiplier: ac = a*c, bc = b*c (a, b signed; c unsigned),
// MULT_LAT cycles from m_en to m_valid, one issue per cycle.
// Ports: clk; m (slave side of the controller bus). m_rst synchronously
// flushes the valid pipeline so no in-flight result survives a flush.
module dsp_dual_mult
    import dual_mac_pkg::*;
(
    input logic                 clk,
    dual_mult_mac_ctrl_if.slave m
);

    logic signed [PROD_W-1:0] a_ext;
    logic signed [PROD_W-1:0] b_ext;
    logic signed [PROD_W-1:0] c_ext;
    product_t                 prod_c;
    product_t                 pipe_q [MULT_LAT];
    logic [MULT_LAT-1:0]      vld_q;

    // c is unsigned: zero-extend so it multiplies as a non-negative value.
    always_comb begin
        a_ext     = {{(PROD_W - DATA_W){m.m_a[DATA_W-1]}}, m.m_a};
        b_ext     = {{(PROD_W - DATA_W){m.m_b[DATA_W-1]}}, m.m_b};
        c_ext     = {{(PROD_W - DATA_W){1'b0}}, m.m_c};
        prod_c.ac = a_ext * c_ext;
        prod_c.bc = b_ext * c_ext;
    end

    // Product/valid pipeline; only the valid bits need flushing.
    always_ff @(posedge clk) begin
        if (m.m_rst) begin
            vld_q <= '0;
        end else begin
            vld_q <= {vld_q[MULT_LAT-2:0], m.m_en};
        end
        pipe_q[0] <= prod_c;
        for (int i = 1; i < MULT_LAT; i++) begin
            pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign m.m_valid = vld_q[MULT_LAT-1];
    assign m.m_ac    = pipe_q[MULT_LAT-1].ac;
    assign m.m_bc    = pipe_q[MULT_LAT-1].bc;

endmodule

// File: rtl/dual_mult_mac_ctrl.sv
// Sequencing controller for a shared dsp_dual_mult: takes a term count, streams
// operand triples into the multiplier and accumulates both product streams into
// a pair of dot products returned on a valid/ready result port.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   start, cmd_len          command strobe / term count (accepted in IDLE only)
//   in_valid/in_ready       operand beat handshake; in_a, in_b signed, in_c unsigned
//   m                       multiplier bus (master side)
//   out_valid/out_ready     result handshake; out_acc_a, out_acc_b signed sums
//   busy, err               not-idle indicator, sticky protocol error
module dual_mult_mac_ctrl
    import dual_mac_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic        [LEN_W-1:0]   cmd_len,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [DATA_W-1:0]  in_a,
    input  logic signed [DATA_W-1:0]  in_b,
    input  logic        [DATA_W-1:0]  in_c,
    dual_mult_mac_ctrl_if.master      m,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [ACC_W-1:0]   out_acc_a,
    output logic signed [ACC_W-1:0]   out_acc_b,
    output logic                      busy,
    output logic                      err
);

    state_t                   state_q, state_d;
    logic [LEN_W-1:0]         len_q, len_d;
    logic [LEN_W-1:0]         issue_q, issue_d;
    logic [LEN_W-1:0]         ret_q, ret_d;
    logic [WDOG_W-1:0]        wdog_q, wdog_d;
    logic signed [ACC_W-1:0]  acc_a_q, acc_a_d;
    logic signed [ACC_W-1:0]  acc_b_q, acc_b_d;
    logic                     err_q, err_d;
    logic                     in_ready_d, out_valid_d, busy_d;
    logic                     flush_c;
    logic                     acc_ok_c;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            len_q     <= '0;
            issue_q   <= '0;
            ret_q     <= '0;
            wdog_q    <= '0;
            acc_a_q   <= '0;
            acc_b_q   <= '0;
            err_q     <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            issue_q   <= issue_d;
            ret_q     <= ret_d;
            wdog_q    <= wdog_d;
            acc_a_q   <= acc_a_d;
            acc_b_q   <= acc_b_d;
            err_q     <= err_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            busy      <= busy_d;
        end
    end

    // Next state, accumulation and registered-output decode.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        issue_d = issue_q;
        ret_d   = ret_q;
        wdog_d  = wdog_q;
        acc_a_d = acc_a_q;
        acc_b_d = acc_b_q;
        err_d   = err_q;
        flush_c = 1'b0;

        // A result only counts if a matching issue is still outstanding.
        acc_ok_c = m.m_valid && (state_q == RUN || state_q == DRAIN) && (ret_q != issue_q);
        if (acc_ok_c) begin
            acc_a_d = acc_a_q + sext_prod(m.m_ac);
            acc_b_d = acc_b_q + sext_prod(m.m_bc);
            ret_d   = ret_q + LEN_W'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    len_d   = cmd_len;
                    issue_d = '0;
                    ret_d   = '0;
                    wdog_d  = '0;
                    acc_a_d = '0;
                    acc_b_d = '0;
                    if (cmd_len == '0) begin
                        state_d = DONE;
                    end else begin
                        err_d   = 1'b0;
                        flush_c = 1'b1;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (in_valid) begin
                    issue_d = issue_q + LEN_W'(1);
                    if (issue_d == len_q) begin
                        state_d = DRAIN;
                        wdog_d  = '0;
                    end
                end
            end
            DRAIN: begin
                // The last result is folded in on the same edge that enters DONE.
                if (acc_ok_c && ret_d == len_q) begin
                    state_d = DONE;
                end else if (m.m_valid) begin
                    wdog_d = '0;
                end else if (wdog_q == WDOG_W'(WDOG_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    wdog_d = wdog_q + WDOG_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (m.m_valid && !acc_ok_c) begin
            err_d = 1'b1;
        end

        in_ready_d  = (state_d == RUN);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    // Multiplier issue is a direct pass-through of the operand stream.
    assign m.m_rst    = ~rst_n | flush_c;
    assign m.m_en     = (state_q == RUN) & in_valid;
    assign m.m_a      = in_a;
    assign m.m_b      = in_b;
    assign m.m_c      = in_c;

    assign out_acc_a  = acc_a_q;
    assign out_acc_b  = acc_b_q;
    assign err        = err_q;

endmodule

// File: tb/tb_dual_mult_mac_ctrl.sv
// Bench for dual_mult_mac_ctrl driving a dsp_dual_mult through the m_* bus.
// A cycle-level behavioural model (term sums, result timing from the last
// accepted beat) is checked against the DUT every cycle, with a few literal
// expectations pinning the model.
module tb_dual_mult_mac_ctrl;
    import dual_mac_pkg::*;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     start;
    logic        [LEN_W-1:0]  cmd_len;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_a;
    logic signed [DATA_W-1:0] in_b;
    logic        [DATA_W-1:0] in_c;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [ACC_W-1:0]  out_acc_a;
    logic signed [ACC_W-1:0]  out_acc_b;
    logic                     busy;
    logic                     err;

    // Spurious-result injection between multiplier and controller.
    logic                     inj_valid;
    logic signed [PROD_W-1:0] inj_ac;
    logic signed [PROD_W-1:0] inj_bc;

    dual_mult_mac_ctrl_if mif();
    dual_mult_mac_ctrl_if dif();

    assign dif.m_rst   = mif.m_rst;
    assign dif.m_en    = mif.m_en;
    assign dif.m_a     = mif.m_a;
    assign dif.m_b     = mif.m_b;
    assign dif.m_c     = mif.m_c;
    assign mif.m_valid = dif.m_valid | inj_valid;
    assign mif.m_ac    = inj_valid ? inj_ac : dif.m_ac;
    assign mif.m_bc    = inj_valid ? inj_bc : dif.m_bc;

    dual_mult_mac_ctrl u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .cmd_len   (cmd_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_c      (in_c),
        .m         (mif),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_acc_a (out_acc_a),
        .out_acc_b (out_acc_b),
        .busy      (busy),
        .err       (err)
    );

    dsp_dual_mult u_mul (
        .clk (clk),
        .m   (dif)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int en_cnt = 0;

    // Current beat as plain integers for the model.
    int cur_a = 0;
    int cur_b = 0;
    int cur_c = 0;

    // Model state.
    bit md_busy = 1'b0;   // command in progress until result handshake
    bit md_take = 1'b0;   // accepting operand beats
    bit md_pend = 1'b0;   // all beats taken, result not yet visible
    bit md_show = 1'b0;   // result presented
    bit md_err  = 1'b0;
    int md_left = 0;
    int md_res_at = 0;
    int md_sa = 0;
    int md_sb = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural model: advances once per clock from the bench's own inputs.
    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                md_busy = 1'b0;
                md_take = 1'b0;
                md_pend = 1'b0;
                md_show = 1'b0;
                md_err  = 1'b0;
                md_left = 0;
                md_sa   = 0;
                md_sb   = 0;
            end else begin
                if (inj_valid && (!md_busy || md_show)) md_err = 1'b1;
                if (md_show && out_ready) begin
                    md_show = 1'b0;
                    md_busy = 1'b0;
                end else if (!md_busy && start) begin
                    md_busy = 1'b1;
                    md_sa   = 0;
                    md_sb   = 0;
                    if (cmd_len == 0) begin
                        md_show = 1'b1;
                    end else begin
                        md_take = 1'b1;
                        md_left = int'(cmd_len);
                        md_err  = 1'b0;
                    end
                end else if (md_take && in_valid) begin
                    md_sa   = md_sa + cur_a * cur_c;
                    md_sb   = md_sb + cur_b * cur_c;
                    md_left = md_left - 1;
                    if (md_left == 0) begin
                        md_take   = 1'b0;
                        md_pend   = 1'b1;
                        md_res_at = cyc + MULT_LAT + 1;
                    end
                end
                if (md_pend && cyc + 1 == md_res_at) begin
                    md_show = 1'b1;
                    md_pend = 1'b0;
                end
            end
            cyc++;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("rst in_ready", in_ready, 0);
                check("rst out_valid", out_valid, 0);
                check("rst busy", busy, 0);
                check("rst err", err, 0);
                check("rst m_en", mif.m_en, 0);
                check("rst m_rst", mif.m_rst, 1);
            end else begin
                check("in_ready", in_ready, md_take);
                check("m_en", mif.m_en, md_take && in_valid);
                check("m_rst", mif.m_rst, !md_busy && start && cmd_len != 0);
                check("out_valid", out_valid, md_show);
                check("busy", busy, md_busy);
                check("err", err, md_err);
                if (md_show) begin
                    check("out_acc_a", out_acc_a, md_sa);
                    check("out_acc_b", out_acc_b, md_sb);
                end
                if (md_take && in_valid) begin
                    check("m_a", mif.m_a, cur_a);
                    check("m_b", mif.m_b, cur_b);
                    check("m_c", mif.m_c, cur_c);
                end
            end
            if (mif.m_en) en_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int len);
        start   = 1'b1;
        cmd_len = LEN_W'(len);
        tick();
        start   = 1'b0;
    endtask

    task automatic beat(input int a, input int b, input int c);
        cur_a    = a;
        cur_b    = b;
        cur_c    = c;
        in_a     = DATA_W'(a);
        in_b     = DATA_W'(b);
        in_c     = DATA_W'(c);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Wait (bounded) for the result, check it, hold, then consume it.
    task automatic wait_result(input string name, input int hold, input int ea, input int eb,
                               output int waited);
        waited = 0;
        while (!out_valid && waited < 40) begin
            tick();
            waited++;
        end
        check({name, " out_valid"}, out_valid, 1);
        check({name, " acc_a"}, out_acc_a, ea);
        check({name, " acc_b"}, out_acc_b, eb);
        repeat (hold) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        int waited;
        int en_base;

        rst_n     = 1'b0;
        start     = 1'b0;
        cmd_len   = '0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_c      = '0;
        out_ready = 1'b0;
        inj_valid = 1'b0;
        inj_ac    = '0;
        inj_bc    = '0;

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        check("reset acc_a", out_acc_a, 0);
        check("reset acc_b", out_acc_b, 0);

        // Single term: 3*5, -2*5; result MULT_LAT+1 cycles after the beat.
        en_base = en_cnt;
        do_start(1);
        beat(3, -2, 5);
        wait_result("t1", 0, 15, -10, waited);
        check("t1 latency", waited, 4);
        check("t1 m_en count", en_cnt - en_base, 1);
        tick();

        // Four back-to-back extreme beats.
        do_start(4);
        repeat (4) beat(-128, 127, 255);
        check("t2 in_ready drop", in_ready, 0);
        wait_result("t2", 0, -130560, 129540, waited);
        tick();

        // Gapped beats, result held under backpressure.
        do_start(3);
        beat(10, -7, 20);
        repeat (2) tick();
        beat(-3, 4, 100);
        repeat (2) tick();
        beat(127, -128, 1);
        wait_result("t3", 10, 27, 132, waited);
        check("t3 busy after", busy, 0);
        check("t3 out_valid after", out_valid, 0);

        // Zero-length command.
        en_base = en_cnt;
        do_start(0);
        check("t4 out_valid", out_valid, 1);
        wait_result("t4", 0, 0, 0, waited);
        check("t4 m_en count", en_cnt - en_base, 0);

        // Reset mid-command with one product accumulated and one in flight.
        do_start(4);
        beat(5, 5, 5);
        beat(5, 5, 5);
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        check("t5 async acc_a", out_acc_a, 0);
        check("t5 async acc_b", out_acc_b, 0);
        check("t5 async in_ready", in_ready, 0);
        check("t5 async busy", busy, 0);
        check("t5 async m_rst", mif.m_rst, 1);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        do_start(2);
        beat(1, 1, 7);
        beat(1, 1, 7);
        wait_result("t5", 0, 14, 14, waited);
        tick();

        // Spurious multiplier result while idle.
        inj_ac    = 16'sd100;
        inj_bc    = 16'sd100;
        inj_valid = 1'b1;
        tick();
        inj_valid = 1'b0;
        check("t6 err set", err, 1);
        check("t6 acc_a kept", out_acc_a, 14);
        check("t6 acc_b kept", out_acc_b, 14);
        tick();
        do_start(1);
        check("t6 err cleared", err, 0);
        beat(2, 3, 4);
        wait_result("t6", 0, 8, 12, waited);
        repeat (2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dual_mult_mac_ctrl.md
Name: dual_mult_mac_ctrl

Overview:
Sequencing controller for the shared dsp_dual_mult datapath.
- Accepts a command (term count), then a valid/ready stream of operand triples (a, b, c), and issues them to the dual multiplier.
- Accumulates both product streams (a*c, b*c) into two wide accumulators and returns the dot-product pair on a valid/ready result port.
- Sits between the CNN layer scheduler and one dsp_dual_mult instance; computes two output channels per activation stream.

Parameters:
DATA_W, 8, operand width (a, b signed; c unsigned)
PROD_W, 16, multiplier product width (signed)
ACC_W, 32, accumulator width (signed, wraps modulo 2^ACC_W)
LEN_W, 9, command length width; legal lengths 0..256
MULT_LAT, 4, dsp_dual_mult latency from en to valid_out (fully pipelined, 1 issue/cycle)

Ports:
clk  in  1  clock, all logic rising-edge
rst_n  in  1  asynchronous active-low reset
start  in  1  command strobe, accepted only in IDLE
cmd_len  in  LEN_W  number of terms for this command
in_valid  in  1  operand beat valid
in_ready  out  1  operand beat accepted when in_valid && in_ready
in_a  in  DATA_W  signed weight, channel A
in_b  in  DATA_W  signed weight, channel B
in_c  in  DATA_W  unsigned activation shared by both channels
m_rst  out  1  multiplier reset/flush (active-high)
m_en  out  1  multiplier issue
m_a, m_b, m_c  out  DATA_W  multiplier operands
m_ac, m_bc  in  PROD_W  multiplier results (signed)
m_valid  in  1  multiplier valid_out
out_valid  out  1  result valid
out_ready  in  1  result consumed when out_valid && out_ready
out_acc_a, out_acc_b  out  ACC_W  signed accumulated sums
busy  out  1  state != IDLE
err  out  1  sticky protocol error flag

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; acc_a, acc_b, issue_cnt, ret_cnt = 0; out_valid = 0; err = 0; in_ready = 0; m_en = 0; m_rst = 1.
- m_rst = ~rst_n OR flush pulse. The flush pulse is 1 cycle, in the cycle start is accepted.
- FSM: IDLE, RUN, DRAIN, DONE.
- IDLE: in_ready = 0.
  - start with cmd_len = 0 -> DONE, accumulators zero, no m_en.
  - start with cmd_len > 0 -> latch len, clear acc and counters, clear err, flush pulse -> RUN.
- RUN: in_ready = 1.
  - m_en = in_valid; m_a/m_b/m_c = in_a/in_b/in_c, combinational pass-through.
  - Each accepted beat increments issue_cnt.
  - The beat that makes issue_cnt == len moves to DRAIN; in_ready drops the next cycle.
- Accumulate in any state except IDLE/DONE: on m_valid, acc_a += sign-extend(m_ac), acc_b += sign-extend(m_bc), ret_cnt++.
- DRAIN: in_ready = 0, m_en = 0.
  - ret_cnt == len -> DONE.
  - Watchdog: no m_valid for 2*MULT_LAT consecutive cycles -> err = 1, DONE with partial sums.
- DONE: out_valid = 1; out_acc_a/b held stable until out_ready -> IDLE. out_valid deasserts the cycle after the handshake.
- Latency: the last beat accepted at cycle T gives out_valid high at T + MULT_LAT + 1. A single accumulation cycle is included.
- Simultaneous accumulate and transition: the final m_valid is accumulated in the same edge that enters DONE; out_acc reflects all len terms.
- start outside IDLE is ignored (no effect, no error).
- m_valid while ret_cnt == issue_cnt, or in IDLE/DONE: ignored for accumulation, err = 1.
- Overflow wraps modulo 2^ACC_W. Max magnitude 256*32640 is well below 2^31.
- Reset mid-operation: all of the above reset values immediately; in-flight multiplier results are discarded via m_rst.

Decomposition:
- Package dual_mac_pkg holds:
  - state enum (IDLE, RUN, DRAIN, DONE)
  - DATA_W, PROD_W, ACC_W defaults
  - LEN_W
  - WDOG_CYCLES = 2*MULT_LAT
- No sub-module in RTL; dsp_dual_mult is instantiated alongside by the parent.
- The bench instantiates dual_mult_mac_ctrl plus dsp_dual_mult connected via the m_* ports.

Test Plan:
- cmd_len=1, a=3, b=-2, c=5 -> out_acc_a=15, out_acc_b=-10; out_valid at T+MULT_LAT+1 after the beat; exactly 1 m_en pulse.
- cmd_len=4, back-to-back a=-128, b=127, c=255 -> out_acc_a=-130560, out_acc_b=129540; in_ready low from the cycle after beat 4.
- cmd_len=3 with in_valid gaps of 2 cycles, out_ready held low 10 cycles -> out_acc stable and out_valid held; busy=1 until the handshake, then IDLE.
- cmd_len=0 -> out_valid next cycle with out_acc_a=out_acc_b=0; m_en never asserted.
- rst_n low after 2 of 4 beats -> all outputs at reset values asynchronously. A following start with cmd_len=2, (a=1, b=1, c=7) x2 -> 14, 14, with no stale products.
- Spurious m_valid in IDLE with m_ac=100 -> err=1, accumulators unchanged. The next accepted start clears err.
